tdc_phase_encoder: RTL and testbench

- Digital model of the TDC analog front end for the WSN ADPLL testbench and FPGA emulation.
- Keeps a 12-bit phase accumulator and converts it each cycle into the 7-bit ring counter word and the 16-bit cyclic thermometer phase word that the TDC digital back end consumes.
- Produces words such that the back end's tdc_word equals the per-cycle accumulator increment, modulo 4096.
- Applies a nominal per-cycle step plus one-shot signed offsets queued through a valid/ready FIFO.

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_therm_enc.sv | 17 +
 rtl/tdc_phase_encoder.sv | 98 +++++++++
 tb/tb_tdc_phase_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared TDC word geometry for the phase encoder and back end
package tdc_pkg;

  localparam int TDC_NPH = 16;  // thermometer phase taps
  localparam int TDC_CW  = 7;   // ring counter width
  localparam int TDC_WW  = 12;  // phase accumulator / tdc_word width
  localparam int TDC_FW  = 5;   // fine field width inside the accumulator

  // Coarse word carries -c plus the back end's phase[0] compensation.
  function automatic logic [TDC_CW-1:0] tdc_coarse_word(input logic [TDC_CW-1:0] c,
                                                         input logic             fine_low);
    return (TDC_CW'(0) - c) + {{(TDC_CW-1){1'b0}}, fine_low};
  endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// rtl/tdc_therm_enc.sv - fine field to 16-bit cyclic thermometer phase word
module tdc_therm_enc
  import tdc_pkg::*;
(
  input  logic [TDC_FW-1:0]  f,
  output logic [TDC_NPH-1:0] phase
);

  // Lower half of the fine range fills ones from bit 0; upper half drains them.
  always_comb begin
    phase = '0;
    for (int i = 0; i < TDC_NPH; i++) begin
      phase[i] = f[TDC_FW-1] ^ (i <= int'(f[TDC_FW-2:0]));
    end
  end

endmodule

// File: rtl/tdc_phase_encoder.sv
// rtl/tdc_phase_encoder.sv - phase accumulator with offset FIFO driving TDC counter/phase words
module tdc_phase_encoder
  import tdc_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [TDC_WW-1:0] ACC_INIT   = 12'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [TDC_WW-1:0]             step_nom,
  input  logic                          offs_valid,
  input  logic [TDC_WW-1:0]             offs_data,
  output logic                          offs_ready,
  output logic [TDC_CW-1:0]             counter_out,
  output logic [TDC_NPH-1:0]            phase_out,
  output logic [TDC_WW-1:0]             acc_out,
  output logic [$clog2(FIFO_DEPTH):0]   offs_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TDC_WW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [TDC_WW-1:0]  acc_q;

  logic               push;
  logic               pop;
  logic [TDC_WW-1:0]  head;
  logic [TDC_WW-1:0]  acc_next;
  logic [TDC_NPH-1:0] phase_next;
  logic [TDC_CW-1:0]  counter_next;
  logic [TDC_CW-1:0]  init_counter;
  logic [TDC_NPH-1:0] init_phase;

  // Ready comes from the registered count, so a same-cycle pop cannot re-open a full FIFO.
  assign offs_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign offs_count = count_q;
  assign acc_out    = acc_q;

  always_comb begin
    push     = offs_valid && offs_ready;
    pop      = en && (count_q != '0);
    head     = pop ? fifo_mem[rd_ptr] : '0;
    acc_next = en ? (acc_q + step_nom + head) : acc_q;
  end

  tdc_therm_enc u_enc_next (
    .f     (acc_next[TDC_FW-1:0]),
    .phase (phase_next)
  );

  tdc_therm_enc u_enc_init (
    .f     (ACC_INIT[TDC_FW-1:0]),
    .phase (init_phase)
  );

  // The encoding is registered alongside P so all outputs move on the same edge.
  assign counter_next = tdc_coarse_word(acc_next[TDC_WW-1:TDC_FW], ~acc_next[TDC_FW-1]);
  assign init_counter = tdc_coarse_word(ACC_INIT[TDC_WW-1:TDC_FW], ~ACC_INIT[TDC_FW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= ACC_INIT;
      counter_out <= init_counter;
      phase_out   <= init_phase;
    end else begin
      acc_q       <= acc_next;
      counter_out <= counter_next;
      phase_out   <= phase_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= offs_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_phase_encoder.sv
// tb/tb_tdc_phase_encoder.sv - scoreboard bench for tdc_phase_encoder
module tb_tdc_phase_encoder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] step_nom = '0;
  logic        offs_valid = 1'b0;
  logic [11:0] offs_data = '0;
  logic        offs_ready;
  logic [6:0]  counter_out;
  logic [15:0] phase_out;
  logic [11:0] acc_out;
  logic [2:0]  offs_count;

  tdc_phase_encoder #(.FIFO_DEPTH(D), .ACC_INIT(12'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .step_nom    (step_nom),
    .offs_valid  (offs_valid),
    .offs_data   (offs_data),
    .offs_ready  (offs_ready),
    .counter_out (counter_out),
    .phase_out   (phase_out),
    .acc_out     (acc_out),
    .offs_count  (offs_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  acc;
    int  cnt;
    int  ph;
    int  occ;
    int  rdy;
    bit  chk_tdc;
    int  incr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   mdl_p = 0;
  int   mdl_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int exp_phase(input int p);
    int f = p % 32;
    int w = 0;
    for (int i = 0; i < 16; i++) begin
      if (f < 16) begin
        if (i <= f) w |= (1 << i);
      end else begin
        if (i > f - 16) w |= (1 << i);
      end
    end
    return w;
  endfunction

  function automatic int exp_counter(input int p);
    int c = p / 32;
    int f = p % 32;
    return (128 - c + ((f < 16) ? 1 : 0)) % 128;
  endfunction

  // What an independent back end would reconstruct from the two words.
  function automatic int backend_decode(input int c, input int ph);
    int ones = $countones(ph[15:0]);
    int b0   = ph & 1;
    int f    = b0 ? ones - 1 : 31 - ones;
    int cr   = (128 - ((c - b0 + 128) % 128)) % 128;
    return cr * 32 + f;
  endfunction

  task automatic cycle(input bit r, input bit e, input int s, input bit v, input int d);
    exp_t x;
    int   old_p;
    int   head;
    bit   acc;
    @(negedge clk);
    rst        = r;
    en         = e;
    step_nom   = 12'(s);
    offs_valid = v;
    offs_data  = 12'(d);
    old_p = mdl_p;
    if (r) begin
      mdl_p = 0;
      mdl_q.delete();
    end else begin
      acc  = v && (mdl_q.size() < D);
      head = 0;
      if (e) begin
        if (mdl_q.size() > 0) head = mdl_q.pop_front();
        mdl_p = (mdl_p + s + head) % 4096;
      end
      if (acc) mdl_q.push_back(d % 4096);
    end
    x.acc     = mdl_p;
    x.cnt     = exp_counter(mdl_p);
    x.ph      = exp_phase(mdl_p);
    x.occ     = mdl_q.size();
    x.rdy     = (mdl_q.size() < D) ? 1 : 0;
    x.chk_tdc = !r;
    x.incr    = (mdl_p - old_p + 4096) % 4096;
    sb.push_back(x);
  endtask

  exp_t m;
  int   prev_dec = 0;
  int   dec;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk("acc_out", int'(acc_out), m.acc);
      chk("counter_out", int'(counter_out), m.cnt);
      chk("phase_out", int'(phase_out), m.ph);
      chk("offs_count", int'(offs_count), m.occ);
      chk("offs_ready", int'(offs_ready), m.rdy);
      dec = backend_decode(int'(counter_out), int'(phase_out));
      if (m.chk_tdc) chk("tdc_word", (dec - prev_dec + 4096) % 4096, m.incr);
      prev_dec = dec;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Nominal step 33 twice
    cycle(0, 1, 33, 0, 0);
    cycle(0, 1, 33, 0, 0);
    // Fine boundaries 15, 16, 31
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 15, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 15, 0, 0);
    // Wrap from FE0 by 040
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 12'hFE0, 0, 0);
    cycle(0, 1, 12'h040, 0, 0);
    // Offset -5 applied with step 33
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 33, 1, 12'hFFB);
    cycle(0, 1, 33, 0, 0);
    // Fill FIFO, stall 5th push, reset mid-stream, then stalled push lands
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 7, 1, 100 + i);
    cycle(0, 0, 7, 1, 104);
    cycle(1, 0, 7, 1, 104);
    cycle(0, 0, 7, 1, 104);
    cycle(0, 0, 7, 0, 0);
    // Push into empty FIFO with en in the same cycle
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 10, 1, 3);
    cycle(0, 1, 10, 0, 0);
    // Full FIFO with simultaneous pop: ready stays low this cycle
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i + 1);
    cycle(0, 1, 2, 1, 50);
    cycle(0, 1, 2, 1, 60);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
            int'($urandom_range(0, 4095)), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 4095)));
    end
    cycle(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
